// File: rtl/cla_mac_accumulator_pkg.sv
// Shared types and default widths for the MAC accumulator slice.
// State encoding is fixed so waveforms stay readable across tools.
package cla_mac_accumulator_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/cla_mac_accumulator_adder.sv
// n-bit carry-lookahead adder, 4-bit lookahead groups chained.
// Width is padded to a multiple of 4; cout is the carry out of bit n-1.
module CLA_Adder #(
  parameter int n = 72
) (
  input  logic [n-1:0] in1,
  input  logic [n-1:0] in2,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  localparam int NB = (n + 3) / 4;
  localparam int NP = NB * 4;

  logic [NP-1:0] a, b, g, p, s;
  logic [NP:0]   full;
  logic          cc, c0, c1, c2, c3;
  logic          unused_hi;

  assign a = NP'(in1);
  assign b = NP'(in2);
  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    cc = cin;
    c0 = 1'b0;
    c1 = 1'b0;
    c2 = 1'b0;
    c3 = 1'b0;
    s  = '0;
    for (int k = 0; k < NB; k++) begin
      c0 = cc;
      c1 = g[4*k]
         | (p[4*k] & c0);
      c2 = g[4*k+1]
         | (p[4*k+1] & g[4*k])
         | (p[4*k+1] & p[4*k] & c0);
      c3 = g[4*k+2]
         | (p[4*k+2] & g[4*k+1])
         | (p[4*k+2] & p[4*k+1] & g[4*k])
         | (p[4*k+2] & p[4*k+1] & p[4*k] & c0);
      cc = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
         | ((&p[4*k+3 -: 4]) & c0);
      s[4*k +: 4] = p[4*k +: 4] ^ {c3, c2, c1, c0};
    end
  end

  // Padding bits are zero, so bit n of the padded sum is the true carry.
  assign full      = {cc, s};
  assign sum       = full[n-1:0];
  assign cout      = full[n];
  assign unused_hi = ^full;

endmodule

// File: rtl/cla_mac_accumulator.sv
// Product-stream accumulator: sums len unsigned products, saturating,
// and hands the total downstream on a valid/ready handshake.
module cla_mac_accumulator
  import cla_mac_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] product,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  sum_w;
  logic              carry_w;
  logic              take_w;
  logic              last_w;

  CLA_Adder #(
    .n(ACC_W)
  ) u_add (
    .in1 (acc_q),
    .in2 (ACC_W'(product)),
    .cin (1'b0),
    .sum (sum_w),
    .cout(carry_w)
  );

  assign take_w = (state_q == ACCUM) && prod_valid;
  assign last_w = (cnt_q + CNT_W'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (len == '0) ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (take_w && last_w) state_d = HOLD;
      end
      HOLD: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = (state_q == ACCUM);
    acc_valid  = (state_q == HOLD);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      acc_d = '0;
      cnt_d = '0;
      len_d = len;
      ovf_d = 1'b0;
    end else if (take_w) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = carry_w ? '1 : sum_w;
      ovf_d = ovf_q | carry_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_mac_accumulator.sv
// Directed bench for cla_mac_accumulator at a narrow width so that
// saturation is reachable; a job-level model is checked every cycle.
module tb_cla_mac_accumulator;

  localparam int PW = 8;
  localparam int AW = 9;
  localparam int CW = 8;
  localparam longint MAXV = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] len;
  logic          prod_valid;
  logic          prod_ready;
  logic [PW-1:0] product;
  logic          acc_valid;
  logic          acc_ready;
  logic [AW-1:0] acc_out;
  logic          overflow;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  cla_mac_accumulator #(
    .PROD_W(PW),
    .ACC_W (AW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .product   (product),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_out   (acc_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Job-level model: 0 = waiting, 1 = collecting, 2 = result pending.
  int     m_phase;
  longint m_sum;
  int     m_cnt;
  int     m_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= 0;
      m_cnt   <= 0;
      m_len   <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_len   <= int'(len);
          m_sum   <= 0;
          m_cnt   <= 0;
          m_phase <= (len == 0) ? 2 : 1;
        end
        1: if (prod_valid) begin
          m_sum <= m_sum + longint'(product);
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_len) m_phase <= 2;
        end
        default: if (acc_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("prod_ready", longint'(prod_ready),
          longint'(m_phase == 1));
    check("acc_valid", longint'(acc_valid),
          longint'(m_phase == 2));
    check("busy", longint'(busy),
          longint'(m_phase != 0));
    check("acc_out", longint'(acc_out),
          (m_sum > MAXV) ? MAXV : m_sum);
    check("overflow", longint'(overflow),
          longint'(m_sum > MAXV));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int l);
    start = 1'b1;
    len   = CW'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int v);
    prod_valid = 1'b1;
    product    = PW'(v);
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic drain();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod_valid = 1'b0;
    product    = '0;
    acc_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_acc_out", longint'(acc_out), 0);
    check("rst_busy", longint'(busy), 0);

    // basic: 6 + 12 + 35
    go(3);
    beat(6);
    beat(12);
    beat(35);
    check("mac_valid", longint'(acc_valid), 1);
    check("mac_sum", longint'(acc_out), 53);
    check("mac_ovf", longint'(overflow), 0);
    drain();
    check("mac_done", longint'(acc_valid), 0);
    check("mac_keep", longint'(acc_out), 53);

    // zero length, stray beat must be dropped
    prod_valid = 1'b1;
    product    = 8'd99;
    go(0);
    check("zl_valid", longint'(acc_valid), 1);
    check("zl_sum", longint'(acc_out), 0);
    tick();
    check("zl_hold", longint'(acc_out), 0);
    prod_valid = 1'b0;
    drain();

    // input and output backpressure
    go(2);
    beat(7);
    tick();
    tick();
    beat(9);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", longint'(acc_valid), 1);
      check("bp_sum", longint'(acc_out), 16);
      tick();
    end
    drain();
    check("bp_idle", longint'(busy), 0);

    // start during ACCUM and during the HOLD handshake is ignored
    go(2);
    beat(5);
    start      = 1'b1;
    len        = 8'd7;
    beat(4);
    start      = 1'b0;
    check("ign_valid", longint'(acc_valid), 1);
    check("ign_sum", longint'(acc_out), 9);
    start = 1'b1;
    drain();
    start = 1'b0;
    check("ign_idle", longint'(busy), 0);
    check("ign_keep", longint'(acc_out), 9);

    // saturation at 9 bits
    go(3);
    beat(255);
    beat(255);
    check("sat_b2", longint'(acc_out), 510);
    check("sat_b2_ovf", longint'(overflow), 0);
    beat(255);
    check("sat_b3", longint'(acc_out), 511);
    check("sat_ovf", longint'(overflow), 1);
    drain();
    go(1);
    check("sat_clr", longint'(overflow), 0);
    check("sat_clr_acc", longint'(acc_out), 0);
    beat(3);
    check("sat_new", longint'(acc_out), 3);
    drain();

    // asynchronous reset mid-job
    go(4);
    beat(10);
    beat(20);
    check("mid_part", longint'(acc_out), 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_acc", longint'(acc_out), 0);
    check("ar_rdy", longint'(prod_ready), 0);
    check("ar_busy", longint'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_idle", longint'(busy), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
